// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives a req/ack data-memory bus from the EX/MEM register and stalls until done.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are not issued and raise bus_err.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_C,
   input  logic [31:0] mem_rD2,
   input  logic        mem_ram_we,
   input  logic        mem_ram_re,
   input  logic [1:0]  mem_ram_wdin_op,
   input  logic [2:0]  mem_ram_rb_op,
   output logic        dram_req,
   output logic        dram_we,
   output logic [31:0] dram_addr,
   output logic [3:0]  dram_be,
   output logic [31:0] dram_wdata,
   input  logic        dram_ack,
   input  logic [31:0] dram_rdata,
   output logic        mem_stall,
   output logic [31:0] ld_data,
   output logic        ld_valid,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   localparam logic [7:0] CNT_MAX = 8'(TIMEOUT_CYC - 1);

   state_e      state_q;
   logic [7:0]  cnt_q;
   logic        req_q, we_q, ld_valid_q, bus_err_q;
   logic [31:0] addr_q, wdata_q, ld_data_q;
   logic [3:0]  be_q;
   logic [1:0]  off_q;
   logic [2:0]  rb_q;

   logic        acc, misalign;
   logic [1:0]  off;
   logic [3:0]  be_d;
   logic [31:0] wdata_d, ld_ext;
   logic [7:0]  rd_b;
   logic [15:0] rd_h;

   assign acc = mem_ram_we | mem_ram_re;
   assign off = mem_C[1:0];

   // Loads always fetch the full word; lane selection happens on the way back.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = mem_rD2;
      if (mem_ram_we) begin
         case (mem_ram_wdin_op)
            2'b01: begin
               be_d    = off[1] ? 4'b1100 : 4'b0011;
               wdata_d = {2{mem_rD2[15:0]}};
            end
            2'b10: begin
               be_d    = 4'b0001 << off;
               wdata_d = {4{mem_rD2[7:0]}};
            end
            default: ;
         endcase
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic is_half, is_byte;
   always_comb begin
      if (mem_ram_we) begin
         is_half = (mem_ram_wdin_op == 2'b01);
         is_byte = (mem_ram_wdin_op == 2'b10);
      end else begin
         is_half = (mem_ram_rb_op == 3'b001) || (mem_ram_rb_op == 3'b010);
         is_byte = (mem_ram_rb_op == 3'b011) || (mem_ram_rb_op == 3'b100);
      end
   end
   assign misalign = is_half ? off[0] : (!is_byte && (off != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign rd_b = dram_rdata[{off_q, 3'b000} +: 8];
   assign rd_h = dram_rdata[{off_q[1], 4'b0000} +: 16];

   always_comb begin
      case (rb_q)
         3'b001:  ld_ext = {{16{rd_h[15]}}, rd_h};
         3'b010:  ld_ext = {16'h0000, rd_h};
         3'b011:  ld_ext = {{24{rd_b[7]}}, rd_b};
         3'b100:  ld_ext = {24'h000000, rd_b};
         default: ld_ext = dram_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         ld_valid_q <= 1'b0;
         bus_err_q  <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ld_data_q  <= '0;
         be_q       <= '0;
         off_q      <= '0;
         rb_q       <= '0;
      end else begin
         ld_valid_q <= 1'b0;
         bus_err_q  <= 1'b0;
         case (state_q)
            IDLE: if (acc) begin
               cnt_q <= '0;
               if (misalign) begin
                  bus_err_q <= 1'b1;
                  state_q   <= DONE;
               end else begin
                  addr_q  <= {mem_C[31:2], 2'b00};
                  be_q    <= be_d;
                  wdata_q <= wdata_d;
                  we_q    <= mem_ram_we;
                  off_q   <= off;
                  rb_q    <= mem_ram_rb_op;
                  req_q   <= 1'b1;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               // Ack takes precedence over an expiring wait counter.
               if (dram_ack) begin
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  state_q <= DONE;
                  if (!we_q) begin
                     ld_data_q  <= ld_ext;
                     ld_valid_q <= 1'b1;
                  end
               end else if (cnt_q == CNT_MAX) begin
                  req_q     <= 1'b0;
                  we_q      <= 1'b0;
                  bus_err_q <= 1'b1;
                  state_q   <= DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // DONE deliberately releases the stall so the pipeline moves past this instruction.
   assign mem_stall  = ((state_q == IDLE) && acc) || (state_q == BUSY);
   assign dram_req   = req_q;
   assign dram_we    = we_q;
   assign dram_addr  = addr_q;
   assign dram_be    = be_q;
   assign dram_wdata = wdata_q;
   assign ld_data    = ld_data_q;
   assign ld_valid   = ld_valid_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases then random accesses against an arithmetic model.
module tb_mem_stage_lsu;
   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] mem_C, mem_rD2, dram_addr, dram_wdata, dram_rdata, ld_data;
   logic        mem_ram_we, mem_ram_re, dram_req, dram_we, dram_ack, mem_stall, ld_valid, bus_err;
   logic [1:0]  mem_ram_wdin_op;
   logic [2:0]  mem_ram_rb_op;
   logic [3:0]  dram_be;

   int          total = 0;
   int          bad = 0;
   logic [31:0] ld_exp = 32'h0;

   mem_stage_lsu #(.TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst_n(rst_n), .mem_C(mem_C), .mem_rD2(mem_rD2),
      .mem_ram_we(mem_ram_we), .mem_ram_re(mem_ram_re),
      .mem_ram_wdin_op(mem_ram_wdin_op), .mem_ram_rb_op(mem_ram_rb_op),
      .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr), .dram_be(dram_be),
      .dram_wdata(dram_wdata), .dram_ack(dram_ack), .dram_rdata(dram_rdata),
      .mem_stall(mem_stall), .ld_data(ld_data), .ld_valid(ld_valid), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_ld(input logic [2:0] op, input logic [31:0] c, input logic [31:0] rd);
      int unsigned o, bv, hv;
      o  = c % 4;
      bv = (rd >> (8 * o)) & 255;
      hv = (rd >> (16 * (o / 2))) & 65535;
      case (op)
         3'd1:    return (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
         3'd2:    return hv;
         3'd3:    return (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
         3'd4:    return bv;
         default: return rd;
      endcase
   endfunction

   // One access from the first IDLE cycle to the IDLE after DONE; dly = ack delay in BUSY cycles.
   task automatic xact(input logic we, input logic re, input logic [1:0] wop, input logic [2:0] rop,
                       input logic [31:0] c, input logic [31:0] d, input int dly, input logic [31:0] rd);
      int unsigned o;
      int          busy;
      bit          tmo;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      o   = c % 4;
      ebe = 4'hF;
      ewd = d;
      if (we && wop == 2'd2) begin
         ebe = 4'(1 << o);
         ewd = (d & 255) * 32'h0101_0101;
      end else if (we && wop == 2'd1) begin
         ebe = (o >= 2) ? 4'hC : 4'h3;
         ewd = (d & 65535) * 32'h0001_0001;
      end
      tmo  = (dly >= T);
      busy = tmo ? T : dly + 1;
      mem_C = c; mem_rD2 = d; mem_ram_we = we; mem_ram_re = re;
      mem_ram_wdin_op = wop; mem_ram_rb_op = rop;
      #1 chk("idle_stall", 32'(mem_stall), 32'd1);
      for (int k = 0; k < busy; k++) begin
         @(negedge clk);
         chk("busy_req", 32'(dram_req), 32'd1);
         chk("busy_stall", 32'(mem_stall), 32'd1);
         chk("busy_addr", dram_addr, c & 32'hFFFF_FFFC);
         chk("busy_we", 32'(dram_we), 32'(we));
         if (we) begin
            chk("busy_be", 32'(dram_be), 32'(ebe));
            chk("busy_wdata", dram_wdata, ewd);
         end
         dram_ack   = (k == dly);
         dram_rdata = (k == dly) ? rd : $urandom;
      end
      @(negedge clk);
      dram_ack = 1'b0;
      chk("done_stall", 32'(mem_stall), 32'd0);
      chk("done_req", 32'(dram_req), 32'd0);
      chk("done_bus_err", 32'(bus_err), 32'(tmo));
      chk("done_ld_valid", 32'(ld_valid), 32'(!we && !tmo));
      if (!we && !tmo) ld_exp = ref_ld(rop, c, rd);
      chk("done_ld_data", ld_data, ld_exp);
      mem_ram_we = 1'b0; mem_ram_re = 1'b0;
      @(negedge clk);
      chk("idle_ld_valid", 32'(ld_valid), 32'd0);
      chk("idle_bus_err", 32'(bus_err), 32'd0);
      chk("idle_req", 32'(dram_req), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; mem_C = '0; mem_rD2 = '0; mem_ram_we = 1'b0; mem_ram_re = 1'b0;
      mem_ram_wdin_op = '0; mem_ram_rb_op = '0; dram_ack = 1'b0; dram_rdata = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_req", 32'(dram_req), 32'd0);
      chk("rst_we", 32'(dram_we), 32'd0);
      chk("rst_addr", dram_addr, 32'd0);
      chk("rst_be", 32'(dram_be), 32'd0);
      chk("rst_wdata", dram_wdata, 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_ld_valid", 32'(ld_valid), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      xact(1, 0, 2'b00, 3'd0, 32'h100, 32'hDEAD_BEEF, 2, 32'h0);
      xact(1, 0, 2'b10, 3'd0, 32'h103, 32'h0000_00A5, 0, 32'h0);
      xact(0, 1, 2'b00, 3'd3, 32'h102, 32'h0, 0, 32'h0080_0000);
      chk("lb_value", ld_data, 32'hFFFF_FF80);
      xact(0, 1, 2'b00, 3'd4, 32'h102, 32'h0, 1, 32'h0080_0000);
      chk("lbu_value", ld_data, 32'h0000_0080);
      xact(0, 1, 2'b00, 3'd1, 32'h102, 32'h0, 0, 32'h8001_0000);
      chk("lh_value", ld_data, 32'hFFFF_8001);
      xact(0, 1, 2'b00, 3'd0, 32'h200, 32'h0, 10, 32'h0);
      chk("timeout_ld_kept", ld_data, 32'hFFFF_8001);
      xact(0, 1, 2'b00, 3'd0, 32'h204, 32'h0, T - 1, 32'h1234_5678);
      xact(1, 1, 2'b01, 3'd0, 32'h101, 32'h0000_BEEF, 0, 32'h0);
      xact(0, 1, 2'b00, 3'd0, 32'h102, 32'h0, 0, 32'hCAFE_F00D);
      chk("misaligned_lw", ld_data, 32'hCAFE_F00D);

      // Reset while BUSY, then a stray ack in IDLE
      mem_C = 32'h300; mem_ram_re = 1'b1; mem_ram_rb_op = 3'd0;
      @(negedge clk);
      chk("pre_rst_req", 32'(dram_req), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_req", 32'(dram_req), 32'd0);
      chk("async_rst_ld_valid", 32'(ld_valid), 32'd0);
      chk("async_rst_bus_err", 32'(bus_err), 32'd0);
      mem_ram_re = 1'b0;
      ld_exp = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      dram_ack = 1'b1; dram_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      dram_ack = 1'b0;
      chk("stray_ack_req", 32'(dram_req), 32'd0);
      chk("stray_ack_ld_valid", 32'(ld_valid), 32'd0);
      chk("stray_ack_ld_data", ld_data, 32'd0);
      xact(0, 1, 2'b00, 3'd2, 32'h306, 32'h0, 1, 32'hABCD_1234);

      for (int i = 0; i < 40; i++) begin
         logic w, r;
         w = 1'($urandom % 2);
         r = w ? 1'($urandom % 2) : 1'b1;
         xact(w, r, 2'($urandom % 4), 3'($urandom % 8), $urandom, $urandom,
              int'($urandom % 6), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
